// File: rtl/ram_bus_responder_pkg.sv
// ram_bus_responder_pkg: shared encodings for the RAM bus responder.
//   BUS_W   - width of the shared DATA bus and of each memory word
//   state_t - responder FSM states (IDLE, WAIT, DONE)
//   op_t    - access kind latched at request time (READ, WRITE)
package ram_bus_responder_pkg;

    localparam int BUS_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

endpackage

// File: rtl/ram_bus_responder_if.sv
// ram_bus_responder_if: request/acknowledge signals between the control unit and the RAM responder.
//   ADDR_IN     - address from the MAR register (low ADDR_BITS used)
//   RAM_read    - read request level, held until MFC
//   RAM_write   - write request level, held until MFC
//   MFC         - memory function complete acknowledge
//   busy        - responder is not idle
//   REG_OUT_MDR - debug copy of the read-data register
// The shared DATA bus is a resolved tri-state net and is wired as a separate inout port.
interface ram_bus_responder_if;
    import ram_bus_responder_pkg::*;

    logic [BUS_W-1:0] ADDR_IN;
    logic             RAM_read;
    logic             RAM_write;
    logic             MFC;
    logic             busy;
    logic [BUS_W-1:0] REG_OUT_MDR;

    modport master (
        output ADDR_IN, RAM_read, RAM_write,
        input  MFC, busy, REG_OUT_MDR
    );

    modport slave (
        input  ADDR_IN, RAM_read, RAM_write,
        output MFC, busy, REG_OUT_MDR
    );

endinterface

// File: rtl/ram_bus_responder_ram_array.sv
// ram_bus_responder_ram_array: single-port word array, synchronous write, registered read-out, no reset.
//   clk   - clock
//   we    - write enable
//   addr  - word address
//   wdata - write data
//   q     - registered read data, mem[addr] as of the previous edge (read-before-write)
module ram_bus_responder_ram_array
    import ram_bus_responder_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [BUS_W-1:0]     wdata,
    output logic [BUS_W-1:0]     q
);

    logic [BUS_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        q <= mem[addr];
    end

endmodule

// File: rtl/ram_bus_responder.sv
// ram_bus_responder: memory-side responder servicing read/write requests with wait states and an MFC handshake.
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high; clears control state but not the memory array
//   DATA  - shared 16-bit tri-state bus; driven only while a read is held in DONE
//   bus   - slave side of ram_bus_responder_if (ADDR_IN, RAM_read, RAM_write, MFC, busy, REG_OUT_MDR)
module ram_bus_responder
    import ram_bus_responder_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    inout  wire  [BUS_W-1:0]   DATA,
    ram_bus_responder_if.slave bus
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 1..15");
    end

    // WAIT spans CNT_LOAD+1 cycles, so MFC rises after edge N+WAIT_CYCLES+1
    // when the request is sampled at edge N.
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

    state_t               state, state_nx;
    op_t                  op;
    logic [3:0]           cnt;
    logic [ADDR_BITS-1:0] addr;
    logic [BUS_W-1:0]     wdata, rdata, ram_q;
    logic                 rd_req, wr_req, start, req_held, cnt_zero, mem_we, drive;

    // Only the low ADDR_BITS address bits select a word; the rest alias.
    wire unused_addr = &{1'b0, bus.ADDR_IN};

    assign rd_req   = bus.RAM_read & ~bus.RAM_write;
    assign wr_req   = bus.RAM_write & ~bus.RAM_read;
    assign start    = rd_req | wr_req;
    assign req_held = (op == OP_READ) ? bus.RAM_read : bus.RAM_write;
    assign cnt_zero = (cnt == 4'd0);
    assign mem_we   = (state == ST_WAIT) && cnt_zero && (op == OP_WRITE);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: state_nx = start    ? ST_WAIT : ST_IDLE;
            ST_WAIT: state_nx = cnt_zero ? ST_DONE : ST_WAIT;
            ST_DONE: state_nx = req_held ? ST_DONE : ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            op    <= OP_READ;
            cnt   <= '0;
            addr  <= '0;
            wdata <= '0;
            rdata <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && start) begin
                op   <= wr_req ? OP_WRITE : OP_READ;
                addr <= bus.ADDR_IN[ADDR_BITS-1:0];
                cnt  <= CNT_LOAD;
                if (wr_req) wdata <= DATA;
            end else if (state == ST_WAIT && !cnt_zero) begin
                cnt <= cnt - 4'd1;
            end
            // ram_q has tracked the latched address since the edge after the request.
            if (state == ST_WAIT && cnt_zero && op == OP_READ) rdata <= ram_q;
        end
    end

    ram_bus_responder_ram_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_ram_array (
        .clk  (clk),
        .we   (mem_we),
        .addr (addr),
        .wdata(wdata),
        .q    (ram_q)
    );

    assign drive           = (state == ST_DONE) && (op == OP_READ) && bus.RAM_read;
    assign DATA            = drive ? rdata : {BUS_W{1'bz}};
    assign bus.MFC         = (state == ST_DONE);
    assign bus.busy        = (state != ST_IDLE);
    assign bus.REG_OUT_MDR = rdata;

endmodule
